// File: rtl/slurm32_cpu_pipeline_pkg.sv
// slurm32_cpu_pipeline_pkg: shared constants, state enum and stage record for the CPU pipeline
package slurm32_cpu_pipeline_pkg;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] INT_BASE = 32'h0100_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam int          N_STAGES = 5;

  typedef enum logic [1:0] {
    RUN,
    HALT,
    DBG_HALT
  } state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } stage_t;

  localparam stage_t BUBBLE = '{word: NOP, pc: 32'd0};

  function automatic logic [31:0] int_word(input logic [3:0] irq);
    return INT_BASE | {28'd0, irq};
  endfunction

endpackage

// File: rtl/slurm32_cpu_pipeline_if.sv
// slurm32_cpu_pipeline_if: instruction fetch bus between the pipeline and instruction memory
interface slurm32_cpu_pipeline_if;

  logic        instruction_request;
  logic        instruction_valid;
  logic [31:0] instruction_address;
  logic [31:0] instruction_in;

  modport master (
    output instruction_request,
    output instruction_address,
    input  instruction_valid,
    input  instruction_in
  );

  modport slave (
    input  instruction_request,
    input  instruction_address,
    output instruction_valid,
    output instruction_in
  );

endinterface

// File: rtl/slurm32_pipeline_stage_reg.sv
// slurm32_pipeline_stage_reg: one pipeline stage register with hold, bubble and advance controls
module slurm32_pipeline_stage_reg
  import slurm32_cpu_pipeline_pkg::*;
(
  input  logic   CLK,
  input  logic   RSTb,
  input  logic   i_hold,
  input  logic   i_bubble,
  input  stage_t i_d,
  output stage_t o_q
);

  // hold beats bubble beats advance; reset empties the stage
  always_ff @(posedge CLK) begin
    if (RSTb) o_q <= BUBBLE;
    else if (!i_hold) o_q <= i_bubble ? BUBBLE : i_d;
  end

endmodule

// File: rtl/slurm32_cpu_pipeline.sv
// slurm32_cpu_pipeline: five-stage fetch pipeline with stall, redirect, interrupt injection and halt control
module slurm32_cpu_pipeline
  import slurm32_cpu_pipeline_pkg::*;
(
  input  logic                           CLK,
  input  logic                           RSTb,
  slurm32_cpu_pipeline_if.master         fetch,
  output logic [31:0]                    pipeline_stage_0,
  output logic [31:0]                    pipeline_stage_1,
  output logic [31:0]                    pipeline_stage_2,
  output logic [31:0]                    pipeline_stage_3,
  output logic [31:0]                    pipeline_stage_4,
  output logic [31:0]                    pc_stage_4,
  input  logic                           halt_request,
  input  logic                           interrupt,
  input  logic [3:0]                     irq,
  input  logic                           load_pc_request,
  input  logic [31:0]                    load_pc_address,
  input  logic                           interrupt_flag_clear,
  input  logic                           interrupt_flag_set,
  input  logic                           memory_request_successful,
  input  logic                           debugger_halt_request,
  input  logic                           debugger_load_pc_request,
  input  logic [31:0]                    debugger_load_pc_address
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_ie;

  stage_t        w_q [N_STAGES];
  stage_t        w_d [N_STAGES];
  logic [N_STAGES-1:0] w_hold;
  logic [N_STAGES-1:0] w_bubble;

  logic w_freeze;
  logic w_dload;
  logic w_stall;
  logic w_load;
  logic w_redirect;
  logic w_quiet;
  logic w_take;
  logic w_fetch;
  logic w_advance_pc;

  // event decode in priority order: debugger halt, debugger load, stall, load, interrupt, halt, fetch
  always_comb begin
    w_freeze     = debugger_halt_request || (r_state == DBG_HALT);
    w_dload      = !w_freeze && debugger_load_pc_request;
    w_stall      = !w_freeze && !w_dload && !memory_request_successful;
    w_load       = !w_freeze && !w_dload && !w_stall && load_pc_request;
    w_redirect   = w_dload || w_load;
    w_quiet      = !w_freeze && !w_stall && !w_redirect;
    w_take       = w_quiet && interrupt && r_ie;
    w_fetch      = !RSTb && w_quiet && !w_take && (r_state == RUN) && !halt_request;
    w_advance_pc = w_fetch && fetch.instruction_valid;
  end

  // per-stage controls: stall holds S0..S3 and bubbles S4, redirect squashes S0 and S1
  always_comb begin
    w_hold      = {N_STAGES{w_freeze}} | {1'b0, {(N_STAGES-1){w_stall}}};
    w_bubble    = '0;
    w_bubble[0] = w_redirect || !(w_take || w_advance_pc);
    w_bubble[1] = w_redirect;
    w_bubble[4] = w_stall;
  end

  // S0 takes either the injected interrupt word or the fetched word, tagged with the current PC
  always_comb begin
    w_d[0] = '{word: w_take ? int_word(irq) : fetch.instruction_in, pc: r_pc};
    for (int n = 1; n < N_STAGES; n++) w_d[n] = w_q[n-1];
  end

  genvar i;
  generate
    for (i = 0; i < N_STAGES; i++) begin : g_stage
      slurm32_pipeline_stage_reg u_stage (
        .CLK      (CLK),
        .RSTb     (RSTb),
        .i_hold   (w_hold[i]),
        .i_bubble (w_bubble[i]),
        .i_d      (w_d[i]),
        .o_q      (w_q[i])
      );
    end
  endgenerate

  // control state, fetch PC and interrupt-enable flag; a taken interrupt keeps PC as its return address
  always_ff @(posedge CLK) begin
    if (RSTb) begin
      r_state <= RUN;
      r_pc    <= 32'd0;
      r_ie    <= 1'b0;
    end else begin
      r_state <= debugger_halt_request ? DBG_HALT :
                 (r_state == DBG_HALT) ? RUN :
                 w_take ? RUN :
                 (w_quiet && (r_state == RUN) && halt_request) ? HALT : r_state;
      r_pc    <= w_dload ? debugger_load_pc_address :
                 w_load ? load_pc_address :
                 w_advance_pc ? r_pc + PC_STEP : r_pc;
      r_ie    <= (w_take || interrupt_flag_clear) ? 1'b0 :
                 interrupt_flag_set ? 1'b1 : r_ie;
    end
  end

  assign fetch.instruction_request = w_fetch;
  assign fetch.instruction_address = r_pc;
  assign pipeline_stage_0          = w_q[0].word;
  assign pipeline_stage_1          = w_q[1].word;
  assign pipeline_stage_2          = w_q[2].word;
  assign pipeline_stage_3          = w_q[3].word;
  assign pipeline_stage_4          = w_q[4].word;
  assign pc_stage_4                = w_q[4].pc;

endmodule

// File: tb/tb_slurm32_cpu_pipeline.sv
// tb_slurm32_cpu_pipeline: directed vectors with a cycle-tagged scoreboard and an independent monitor
module tb_slurm32_cpu_pipeline;
  import slurm32_cpu_pipeline_pkg::*;

  localparam int K_REQ  = 0;
  localparam int K_ADDR = 1;
  localparam int K_S0   = 2;
  localparam int K_PC4  = 7;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b1;
  logic [31:0] stage_0, stage_1, stage_2, stage_3, stage_4, pc4;
  logic        halt_request = 1'b0, interrupt = 1'b0;
  logic [3:0]  irq = 4'd0;
  logic        load_pc_request = 1'b0;
  logic [31:0] load_pc_address = 32'd0;
  logic        interrupt_flag_clear = 1'b0, interrupt_flag_set = 1'b0;
  logic        memory_request_successful = 1'b1;
  logic        debugger_halt_request = 1'b0, debugger_load_pc_request = 1'b0;
  logic [31:0] debugger_load_pc_address = 32'd0;

  exp_t sb[$];
  int   ncyc = 0;
  int   vectors = 0;
  int   errors = 0;
  string names[8] = '{"ireq", "iaddr", "stage0", "stage1", "stage2", "stage3", "stage4", "pc4"};

  slurm32_cpu_pipeline_if bus ();

  slurm32_cpu_pipeline dut (
    .CLK                       (CLK),
    .RSTb                      (RSTb),
    .fetch                     (bus.master),
    .pipeline_stage_0          (stage_0),
    .pipeline_stage_1          (stage_1),
    .pipeline_stage_2          (stage_2),
    .pipeline_stage_3          (stage_3),
    .pipeline_stage_4          (stage_4),
    .pc_stage_4                (pc4),
    .halt_request              (halt_request),
    .interrupt                 (interrupt),
    .irq                       (irq),
    .load_pc_request           (load_pc_request),
    .load_pc_address           (load_pc_address),
    .interrupt_flag_clear      (interrupt_flag_clear),
    .interrupt_flag_set        (interrupt_flag_set),
    .memory_request_successful (memory_request_successful),
    .debugger_halt_request     (debugger_halt_request),
    .debugger_load_pc_request  (debugger_load_pc_request),
    .debugger_load_pc_address  (debugger_load_pc_address)
  );

  initial begin
    bus.instruction_valid = 1'b0;
    bus.instruction_in    = 32'd0;
  end

  always #5 CLK = ~CLK;

  always @(negedge CLK) ncyc <= ncyc + 1;

  function automatic logic [31:0] actual(input int k);
    case (k)
      0: return {31'd0, bus.instruction_request};
      1: return bus.instruction_address;
      2: return stage_0;
      3: return stage_1;
      4: return stage_2;
      5: return stage_3;
      6: return stage_4;
      default: return pc4;
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      while (sb.size() > 0 && sb[0].cyc <= ncyc) begin
        e = sb.pop_front();
        vectors++;
        if (actual(e.kind) !== e.val) begin
          errors++;
          $display("FAIL %s @cycle %0d: got %h expected %h", names[e.kind], e.cyc, actual(e.kind), e.val);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic nxt();
    @(negedge CLK);
    #1;
    RSTb = 1'b0;
    bus.instruction_valid = 1'b0;
    bus.instruction_in = 32'd0;
    halt_request = 1'b0;
    interrupt = 1'b0;
    irq = 4'd0;
    load_pc_request = 1'b0;
    load_pc_address = 32'd0;
    interrupt_flag_clear = 1'b0;
    interrupt_flag_set = 1'b0;
    memory_request_successful = 1'b1;
    debugger_halt_request = 1'b0;
    debugger_load_pc_request = 1'b0;
    debugger_load_pc_address = 32'd0;
  endtask

  task automatic f(input logic [31:0] w);
    bus.instruction_valid = 1'b1;
    bus.instruction_in = w;
  endtask

  task automatic chk(input int k, input int off, input logic [31:0] v);
    sb.push_back('{cyc: ncyc + off, kind: k, val: v});
  endtask

  initial begin : stimulus
    nxt(); RSTb = 1'b1; chk(K_REQ, 0, 0);
    nxt(); RSTb = 1'b1; chk(K_REQ, 0, 0);
    for (int k = K_S0; k <= K_PC4; k++) chk(k, 0, 0);
    nxt(); f(32'h21010203); chk(K_REQ, 0, 1); chk(K_ADDR, 0, 0); chk(K_S0, 1, 32'h21010203);
    nxt(); f(32'h21020304); chk(K_ADDR, 0, 4); chk(K_S0, 1, 32'h21020304); chk(K_S0+1, 1, 32'h21010203);
    nxt(); f(32'h21030405); chk(K_ADDR, 0, 8); chk(K_S0, 1, 32'h21030405); chk(K_S0+1, 1, 32'h21020304);
    chk(K_S0+2, 1, 32'h21010203);
    for (int n = 0; n < 3; n++) begin
      nxt(); chk(K_REQ, 0, 1); chk(K_ADDR, 0, 12); chk(K_S0, 1, 0);
    end
    chk(K_S0+3, 1, 32'h21030405); chk(K_S0+4, 1, 32'h21020304); chk(K_PC4, 1, 4);
    nxt(); f(32'h21040506); chk(K_ADDR, 0, 12); chk(K_S0, 1, 32'h21040506);
    nxt(); interrupt_flag_set = 1'b1; chk(K_ADDR, 0, 16);
    nxt(); interrupt = 1'b1; chk(K_REQ, 0, 0); chk(K_S0, 1, 32'h01000000); chk(K_S0+2, 1, 32'h21040506);
    nxt(); interrupt = 1'b1; f(32'h21050607); chk(K_REQ, 0, 1); chk(K_ADDR, 0, 16);
    chk(K_S0, 1, 32'h21050607); chk(K_S0+1, 1, 32'h01000000);
    nxt(); chk(K_ADDR, 0, 20); chk(K_S0+4, 1, 32'h21040506); chk(K_PC4, 1, 12);
    nxt(); f(32'h21060708); chk(K_ADDR, 0, 20);
    nxt(); f(32'hc0000000); chk(K_ADDR, 0, 24); chk(K_S0+4, 1, 32'h01000000); chk(K_PC4, 1, 16);
    nxt();
    nxt(); interrupt_flag_set = 1'b1;
    nxt(); chk(K_S0+3, 1, 32'hc0000000); chk(K_S0+4, 1, 32'h21060708);
    nxt(); memory_request_successful = 1'b0; interrupt = 1'b1; irq = 4'd5; f(32'hdeadbeef);
    chk(K_REQ, 0, 0); chk(K_S0+3, 1, 32'hc0000000); chk(K_S0+4, 1, 0);
    nxt(); memory_request_successful = 1'b0; interrupt = 1'b1; irq = 4'd5;
    chk(K_REQ, 0, 0); chk(K_S0, 1, 0); chk(K_S0+3, 1, 32'hc0000000); chk(K_S0+4, 1, 0);
    nxt(); interrupt = 1'b1; irq = 4'd5;
    chk(K_REQ, 0, 0); chk(K_S0, 1, 32'h01000005); chk(K_S0+4, 1, 32'hc0000000); chk(K_PC4, 1, 24);
    nxt(); f(32'h21070809); chk(K_REQ, 0, 1); chk(K_ADDR, 0, 28);
    chk(K_S0, 1, 32'h21070809); chk(K_S0+1, 1, 32'h01000005);
    nxt(); load_pc_request = 1'b1; load_pc_address = 32'h100; f(32'hdeadbeef);
    chk(K_REQ, 0, 0); chk(K_S0, 1, 0); chk(K_S0+1, 1, 0); chk(K_S0+2, 1, 32'h01000005);
    nxt(); f(32'h21080910); chk(K_REQ, 0, 1); chk(K_ADDR, 0, 32'h100); chk(K_S0, 1, 32'h21080910);
    nxt(); halt_request = 1'b1; interrupt_flag_set = 1'b1; f(32'hdeadbeef);
    nxt(); f(32'hdeadbeef); chk(K_REQ, 0, 0);
    for (int n = 0; n < 4; n++) begin
      nxt(); f(32'hdeadbeef);
    end
    for (int k = K_S0; k < K_PC4; k++) chk(k, 1, 0);
    nxt(); interrupt = 1'b1; irq = 4'd3; chk(K_REQ, 0, 0); chk(K_S0, 1, 32'h01000003);
    nxt(); f(32'h210a0b0c); chk(K_REQ, 0, 1); chk(K_ADDR, 0, 32'h104); chk(K_S0, 1, 32'h210a0b0c);
    nxt(); debugger_halt_request = 1'b1; f(32'hdeadbeef);
    chk(K_REQ, 0, 0); chk(K_S0, 1, 32'h210a0b0c); chk(K_S0+1, 1, 32'h01000003);
    nxt(); debugger_halt_request = 1'b1; chk(K_S0, 1, 32'h210a0b0c);
    nxt(); chk(K_REQ, 0, 0); chk(K_S0, 1, 32'h210a0b0c);
    nxt(); f(32'h210b0c0d); chk(K_REQ, 0, 1); chk(K_ADDR, 0, 32'h108); chk(K_S0, 1, 32'h210b0c0d);
    nxt(); debugger_load_pc_request = 1'b1; debugger_load_pc_address = 32'h200;
    load_pc_request = 1'b1; load_pc_address = 32'h300;
    chk(K_REQ, 0, 0); chk(K_S0, 1, 0); chk(K_S0+1, 1, 0); chk(K_S0+2, 1, 32'h210a0b0c);
    nxt(); chk(K_ADDR, 0, 32'h200); chk(K_S0+4, 1, 32'h01000003); chk(K_PC4, 1, 32'h104);
    nxt(); RSTb = 1'b1; chk(K_REQ, 0, 0); chk(K_S0+3, 1, 0); chk(K_S0+4, 1, 0); chk(K_PC4, 1, 0);
    nxt(); chk(K_REQ, 0, 1); chk(K_ADDR, 0, 0);
    nxt(); load_pc_request = 1'b1; load_pc_address = 32'hffff_fffc;
    nxt(); f(32'h210c0d0e); chk(K_ADDR, 0, 32'hffff_fffc); chk(K_S0, 1, 32'h210c0d0e);
    nxt(); chk(K_ADDR, 0, 0);
    nxt();
    nxt();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations never checked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/slurm32_cpu_pipeline.md
SLURM32_CPU_PIPELINE -- requirements
Module: slurm32_cpu_pipeline

Interface
REQ-001 CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 RSTb  in  1  reset, synchronous, active-high.
REQ-003 instruction_request  out  1  pipeline is fetching this cycle.
REQ-004 instruction_valid  in  1  instruction_in holds the word at instruction_address; 0 means cache miss.
REQ-005 instruction_address  out  32  fetch PC.
REQ-006 instruction_in  in  32  fetched instruction word.
REQ-007 pipeline_stage_0..pipeline_stage_4  out  32 each  instruction word held in stages 0..4.
REQ-008 pc_stage_4  out  32  PC of the stage-4 instruction.
REQ-009 halt_request  in  1  sleep instruction requests halt.
REQ-010 interrupt  in  1  interrupt request; irq  in  4  interrupt number.
REQ-011 load_pc_request  in  1  branch taken; load_pc_address  in  32  branch target.
REQ-012 interrupt_flag_clear, interrupt_flag_set  in  1 each  clear/set the interrupt-enable (IE) flag.
REQ-013 memory_request_successful  in  1  0 means the stage-3 memory access failed and must be retried.
REQ-014 debugger_halt_request  in  1; debugger_load_pc_request  in  1; debugger_load_pc_address  in  32.

Function
REQ-015 Five stage registers S0..S4, each holding a 32-bit word and its 32-bit PC; S0 is fed from fetch and Sn+1 takes Sn when advancing.
REQ-016 NOP = 32'h00000000; INT word = 32'h01000000 | irq (irq in bits 3:0).
REQ-017 States: RUN, HALT, DBG_HALT. RUN->HALT on halt_request; HALT->RUN on an accepted interrupt; any state->DBG_HALT while debugger_halt_request=1; DBG_HALT->RUN when it drops.
REQ-018 instruction_request=1 only in RUN with no memory stall, no pending interrupt injection and no PC load this cycle.
REQ-019 When instruction_request=1 and instruction_valid=1: S0 <= {instruction_in, PC}, PC <= PC+4 (32-bit wrap). When instruction_valid=0: S0 <= NOP and PC holds.
REQ-020 In HALT, NOPs enter S0 and the pipeline drains; PC holds.
REQ-021 In DBG_HALT, all stages and PC freeze; outputs hold.
REQ-022 Memory stall (memory_request_successful=0): S0..S3 and PC hold, S4 <= NOP, no fetch; normal flow resumes the cycle after it returns to 1.
REQ-023 load_pc_request: PC <= load_pc_address; S0 and S1 <= NOP (squash wrong-path words); others advance.
REQ-024 debugger_load_pc_request: same as REQ-023 with debugger_load_pc_address; takes priority over load_pc_request.
REQ-025 IE: set by interrupt_flag_set, cleared by interrupt_flag_clear; clear wins when both are asserted.
REQ-026 Interrupt accepted when interrupt=1, IE=1, not in DBG_HALT, no memory stall and no PC load that cycle: S0 <= {INT word, PC}, PC holds as return address, IE cleared in the same cycle.
REQ-027 An interrupt during a memory stall or PC load is deferred, not lost, while interrupt stays high.
REQ-028 Priority, high to low: reset, debugger halt, debugger load PC, memory stall, load PC, interrupt, halt, fetch.
REQ-029 pipeline_stage_n = Sn word; pc_stage_4 = S4 PC.

Reset
REQ-030 While RSTb=1: PC=0, all stages NOP with PC 0, IE=0, state RUN, instruction_request=0.
REQ-031 Reset mid-operation discards all in-flight words within one cycle.
REQ-032 instruction_request=1 from the first cycle after reset is released.

Structure
REQ-033 Shared package holds the NOP and INT constants, the state enum, and the stage struct {word, pc}.
REQ-034 One sub-module, slurm32_pipeline_stage_reg (stage register with hold/advance/bubble controls), is instantiated five times; the rest is a single module of 120-400 lines.

Verification
REQ-035 Release reset, valid words 21010203, 21020304, 21030405 on consecutive cycles -> stage_0..stage_2 show them in order; instruction_address 0, 4, 8, then 12.
REQ-036 instruction_valid=0 for 3 cycles -> 3 NOPs enter S0; PC stays 12; fetch resumes at 12.
REQ-037 interrupt_flag_set, then interrupt=1 with irq=0 -> S0 = 01000000 next cycle; PC held; IE=0; no second injection while interrupt stays high.
REQ-038 Word c0000000 reaches S3 with memory_request_successful=0 -> S0..S3 frozen, S4 = NOP; interrupt raised meanwhile is injected only after success returns to 1.
REQ-039 load_pc_request with address 0x100 -> S0 and S1 become NOP; next fetch address is 0x100.
REQ-040 halt_request, then interrupt with IE=1 -> pipeline drains to NOPs, then INT is injected and state returns to RUN.
